// File: rtl/unstriping_sched.sv
// Purpose: read scheduler for two-lane un-striping; aligns both lanes, then pops them alternately (lane 0 first).
// Latency: pop strobes are combinational from registered state; valid_out/sel_lane follow the pop by 1 cycle.
// Backpressure: a lane that is empty when its turn comes holds the turn; persistent starvation ends in STALL.
// Build option: define UNSTRIPING_WORDCNT_EN to include the delivered-word counter; otherwise word_count is 0.
module unstriping_sched #(
   parameter int ALIGN_CYCLES = 2,
   parameter int TIMEOUT      = 8,
   parameter int CNT_W        = 16
) (
   input  logic             clk_2f,
   input  logic             reset,
   input  logic             enable,
   input  logic             empty_0,
   input  logic             empty_1,
   output logic             pop_0,
   output logic             pop_1,
   output logic             sel_lane,
   output logic             valid_out,
   output logic             err_stall,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] word_count
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ALIGN = 2'd1,
      S_RUN   = 2'd2,
      S_STALL = 2'd3
   } state_e;

   localparam int AW = (ALIGN_CYCLES > 1) ? $clog2(ALIGN_CYCLES) : 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [AW-1:0] ALIGN_LAST   = AW'(ALIGN_CYCLES - 1);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);

   state_e        state_q, state_d;
   logic          next_lane_q, next_lane_d;
   logic [AW-1:0] align_cnt_q, align_cnt_d;
   logic [TW-1:0] stall_cnt_q, stall_cnt_d;
   logic          sel_lane_q, sel_lane_d;
   logic          valid_q, valid_d;
   logic          err_q, err_d;
   logic          pop_any;
   logic          both_rdy;
   logic          lane_rdy;

   assign both_rdy = ~empty_0 & ~empty_1;
   assign lane_rdy = next_lane_q ? ~empty_1 : ~empty_0;

   // Next-state, pop decision and registered-output updates
   always_comb begin
      state_d     = state_q;
      next_lane_d = next_lane_q;
      align_cnt_d = align_cnt_q;
      stall_cnt_d = stall_cnt_q;
      sel_lane_d  = sel_lane_q;
      valid_d     = 1'b0;
      err_d       = err_q;
      pop_any     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (enable && both_rdy) begin
               state_d     = S_ALIGN;
               align_cnt_d = '0;
            end
         end
         S_ALIGN: begin
            if (enable && both_rdy) begin
               if (align_cnt_q == ALIGN_LAST) begin
                  state_d     = S_RUN;
                  next_lane_d = 1'b0;
                  stall_cnt_d = '0;
               end else begin
                  align_cnt_d = align_cnt_q + 1'b1;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            if (!enable && !next_lane_q) begin
               // pair boundary: stop without popping
               state_d = S_IDLE;
            end else if (lane_rdy) begin
               pop_any     = 1'b1;
               valid_d     = 1'b1;
               sel_lane_d  = next_lane_q;
               next_lane_d = ~next_lane_q;
               stall_cnt_d = '0;
               // enable low here means lane 1 just closed the pair
               if (!enable) state_d = S_IDLE;
            end else if (stall_cnt_q == TIMEOUT_LAST) begin
               state_d = S_STALL;
               err_d   = 1'b1;
            end else begin
               stall_cnt_d = stall_cnt_q + 1'b1;
            end
         end
         S_STALL: begin
            if (!enable) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Scheduler state registers
   always_ff @(posedge clk_2f) begin
      if (reset) begin
         state_q     <= S_IDLE;
         next_lane_q <= 1'b0;
         align_cnt_q <= '0;
         stall_cnt_q <= '0;
         sel_lane_q  <= 1'b0;
         valid_q     <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         next_lane_q <= next_lane_d;
         align_cnt_q <= align_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         sel_lane_q  <= sel_lane_d;
         valid_q     <= valid_d;
         err_q       <= err_d;
      end
   end

`ifdef UNSTRIPING_WORDCNT_EN
   logic [CNT_W-1:0] word_cnt_q, word_cnt_d;

   // Delivered-word counter, wraps naturally and survives IDLE
   always_comb begin
      word_cnt_d = word_cnt_q;
      if (pop_any) word_cnt_d = word_cnt_q + 1'b1;
   end

   // Counter register
   always_ff @(posedge clk_2f) begin
      if (reset) word_cnt_q <= '0;
      else       word_cnt_q <= word_cnt_d;
   end

   assign word_count = word_cnt_q;
`else
   assign word_count = '0;
`endif

   assign pop_0     = pop_any & ~next_lane_q;
   assign pop_1     = pop_any &  next_lane_q;
   assign sel_lane  = sel_lane_q;
   assign valid_out = valid_q;
   assign err_stall = err_q;
   assign state     = state_q;

endmodule

// File: tb/tb_unstriping_sched.sv
// Bench for unstriping_sched: directed stimulus, cycle-by-cycle comparison against a behavioural model.
// Model tracks readiness streaks, lane turn and starvation time rather than the scheduler's encoding.
// Word-count expectations follow the UNSTRIPING_WORDCNT_EN build option.
module tb_unstriping_sched;

   localparam int ALIGN_CYCLES = 2;
   localparam int TIMEOUT      = 8;
   localparam int CNT_W        = 4;

   logic             clk_2f = 1'b0;
   logic             reset  = 1'b1;
   logic             enable = 1'b0;
   logic             empty_0 = 1'b1;
   logic             empty_1 = 1'b1;
   logic             pop_0, pop_1, sel_lane, valid_out, err_stall;
   logic [1:0]       state;
   logic [CNT_W-1:0] word_count;

   int n_vec = 0;
   int n_bad = 0;

   unstriping_sched #(
      .ALIGN_CYCLES(ALIGN_CYCLES),
      .TIMEOUT     (TIMEOUT),
      .CNT_W       (CNT_W)
   ) dut (
      .clk_2f    (clk_2f),
      .reset     (reset),
      .enable    (enable),
      .empty_0   (empty_0),
      .empty_1   (empty_1),
      .pop_0     (pop_0),
      .pop_1     (pop_1),
      .sel_lane  (sel_lane),
      .valid_out (valid_out),
      .err_stall (err_stall),
      .state     (state),
      .word_count(word_count)
   );

   always #5 clk_2f = ~clk_2f;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // streak: consecutive cycles with enable and both lanes holding data while not yet running
   bit m_running = 0, m_stalled = 0, m_err = 0;
   int m_streak = 0, m_turn = 0, m_starve = 0, m_words = 0;
   bit m_vld = 0, m_sel = 0;

   function automatic int exp_state();
      if (m_stalled)      return 3;
      else if (m_running) return 2;
      else if (m_streak > 0) return 1;
      else return 0;
   endfunction

   function automatic int exp_words();
`ifdef UNSTRIPING_WORDCNT_EN
      return m_words % (1 << CNT_W);
`else
      return 0;
`endif
   endfunction

   // Compare on the falling edge, then advance the model to what the next rising edge must produce
   always @(negedge clk_2f) begin
      bit will_pop;
      bit lane_has;
      lane_has = (m_turn == 0) ? !empty_0 : !empty_1;
      will_pop = m_running && !(!enable && m_turn == 0) && lane_has;
      chk("state", int'(state), exp_state());
      chk("pop_0", int'(pop_0), int'(will_pop && m_turn == 0));
      chk("pop_1", int'(pop_1), int'(will_pop && m_turn == 1));
      chk("valid_out", int'(valid_out), int'(m_vld));
      chk("sel_lane", int'(sel_lane), int'(m_sel));
      chk("err_stall", int'(err_stall), int'(m_err));
      chk("word_count", int'(word_count), exp_words());

      if (reset) begin
         m_running = 0; m_stalled = 0; m_err = 0; m_streak = 0;
         m_turn = 0; m_starve = 0; m_words = 0; m_vld = 0; m_sel = 0;
      end else if (m_stalled) begin
         m_vld = 0;
         if (!enable) m_stalled = 0;
      end else if (m_running) begin
         if (will_pop) begin
            m_words++;
            m_vld = 1;
            m_sel = bit'(m_turn);
            m_starve = 0;
            if (m_turn == 1 && !enable) m_running = 0;
            m_turn = 1 - m_turn;
         end else begin
            m_vld = 0;
            if (!enable && m_turn == 0) begin
               m_running = 0;
            end else begin
               m_starve++;
               if (m_starve == TIMEOUT) begin
                  m_running = 0; m_stalled = 1; m_err = 1;
               end
            end
         end
      end else begin
         m_vld = 0;
         if (enable && !empty_0 && !empty_1) begin
            m_streak++;
            if (m_streak == ALIGN_CYCLES + 1) begin
               m_running = 1; m_turn = 0; m_starve = 0; m_streak = 0;
            end
         end else begin
            m_streak = 0;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input bit en, input bit e0, input bit e1, input int n);
      for (int i = 0; i < n; i++) begin
         enable = en; empty_0 = e0; empty_1 = e1;
         @(posedge clk_2f);
         #1;
      end
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      for (int i = 0; i < n; i++) begin
         @(posedge clk_2f);
         #1;
      end
      reset = 1'b0;
   endtask

   initial begin
      do_reset(2);
      chk("lit reset state", int'(state), 0);
      chk("lit reset valid", int'(valid_out), 0);
      chk("lit reset wc", int'(word_count), 0);

      // Alignment then alternating pops: RUN after 3 ready cycles
      cyc(1, 0, 0, 3);
      chk("lit run entry state", int'(state), 2);
      chk("lit run entry pop_0", int'(pop_0), 1);
      cyc(1, 0, 0, 1);
      chk("lit first valid", int'(valid_out), 1);
      chk("lit first sel", int'(sel_lane), 0);
      cyc(1, 0, 0, 1);
      chk("lit second sel", int'(sel_lane), 1);
      cyc(1, 0, 0, 8);                        // 10 pops total, next turn lane 0

      // Enable drops right after a lane_0 pop: pair completes, then IDLE
      cyc(1, 0, 0, 1);                        // pop lane 0 (11)
      cyc(0, 0, 0, 1);                        // pop lane 1 (12) -> IDLE
      chk("lit pair idle", int'(state), 0);
      chk("lit pair sel", int'(sel_lane), 1);
`ifdef UNSTRIPING_WORDCNT_EN
      chk("lit pair wc", int'(word_count), 12);
`else
      chk("lit pair wc", int'(word_count), 0);
`endif
      cyc(0, 0, 0, 2);

      // Lane 1 starves for TIMEOUT cycles -> STALL, sticky error
      cyc(1, 0, 0, 3);
      cyc(1, 0, 1, 1);                        // pop lane 0
      cyc(1, 0, 1, 7);
      chk("lit not yet stalled", int'(state), 2);
      cyc(1, 0, 1, 1);
      chk("lit stall state", int'(state), 3);
      chk("lit stall err", int'(err_stall), 1);
      cyc(1, 0, 0, 2);                        // stays stalled while enabled
      chk("lit stall hold", int'(state), 3);
      cyc(0, 0, 0, 1);
      chk("lit stall exit", int'(state), 0);
      chk("lit err sticky", int'(err_stall), 1);

      // Short lane-1 gap: no stall, pop_1 on first non-empty cycle
      do_reset(1);
      cyc(1, 0, 0, 3);
      cyc(1, 0, 0, 1);                        // pop lane 0
      cyc(1, 0, 1, 3);
      chk("lit gap no stall", int'(state), 2);
      chk("lit gap valid", int'(valid_out), 0);
      enable = 1; empty_0 = 0; empty_1 = 0;
      #1;
      chk("lit gap pop_1", int'(pop_1), 1);
      cyc(1, 0, 0, 1);
      chk("lit gap sel", int'(sel_lane), 1);
      chk("lit gap err", int'(err_stall), 0);
      cyc(1, 0, 0, 4);

      // Reset asserted mid-RUN
      do_reset(2);
      chk("lit midrun state", int'(state), 0);
      chk("lit midrun pops", int'(pop_0 | pop_1), 0);
      chk("lit midrun err", int'(err_stall), 0);

      // Word counter wrap: 17 pops on a 4-bit counter
      cyc(1, 0, 0, 3);
      cyc(1, 0, 0, 17);
`ifdef UNSTRIPING_WORDCNT_EN
      chk("lit wrap wc", int'(word_count), 1);
`else
      chk("lit wrap wc", int'(word_count), 0);
`endif
      cyc(0, 0, 0, 3);
      chk("lit final idle", int'(state), 0);
      chk("lit even after pair", int'(word_count) % 2, 0);

      @(negedge clk_2f);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
